// File: rtl/tlb_mp.sv
// Multi-port fully associative joint TLB with even/odd page pairs, TLBP probe,
// Random/Wired replacement counter and a sequential invalidate walker.
module tlb_mp #(
    parameter int unsigned ENTRIES      = 32,
    parameter int unsigned LOOKUP_PORTS = 2,
    localparam int unsigned IDX_W       = $clog2(ENTRIES),
    localparam int unsigned ENTRY_W     = 78
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [7:0]                     asid,
    input  logic [LOOKUP_PORTS-1:0]        lk_valid,
    input  logic [32*LOOKUP_PORTS-1:0]     lk_vaddr,
    output logic [LOOKUP_PORTS-1:0]        res_valid,
    output logic [LOOKUP_PORTS-1:0]        res_hit,
    output logic [IDX_W*LOOKUP_PORTS-1:0]  res_index,
    output logic [32*LOOKUP_PORTS-1:0]     res_paddr,
    output logic [LOOKUP_PORTS-1:0]        res_v,
    output logic [LOOKUP_PORTS-1:0]        res_d,
    output logic [3*LOOKUP_PORTS-1:0]      res_c,
    input  logic                           probe_req,
    input  logic [31:0]                    probe_entry_hi,
    output logic                           probe_ack,
    output logic [31:0]                    probe_index,
    input  logic [IDX_W-1:0]               rd_index,
    output logic [ENTRY_W-1:0]             rd_data,
    input  logic                           wr_en,
    input  logic                           wr_random,
    input  logic [IDX_W-1:0]               wr_index,
    input  logic [ENTRY_W-1:0]             wr_data,
    input  logic [IDX_W-1:0]               wired,
    input  logic                           wired_we,
    output logic [IDX_W-1:0]               random,
    input  logic                           inv_req,
    input  logic                           inv_mode,
    input  logic [7:0]                     inv_asid,
    output logic                           inv_busy,
    output logic                           inv_done
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(ENTRIES - 1);

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    typedef enum logic [1:0] {StIdle, StWalk, StDone} inv_state_e;

    function automatic logic entry_match(input tlb_entry_t e, input logic [18:0] vpn2,
                                         input logic [7:0] id);
        return (e.vpn2 == vpn2) && (e.g || (e.asid == id));
    endfunction

    tlb_entry_t              mem_q [ENTRIES];
    logic [IDX_W-1:0]        random_q, random_d;
    inv_state_e              state_q, state_d;
    logic [IDX_W-1:0]        ptr_q;
    logic                    mode_q;
    logic [7:0]              inv_asid_q;
    logic                    walk_en;
    logic                    walk_clr;
    tlb_entry_t              walk_entry;
    logic [IDX_W-1:0]        wr_idx;

    // ---------------- lookup ports ----------------
    logic [LOOKUP_PORTS-1:0]       lk_hit;
    logic [IDX_W-1:0]              lk_idx [LOOKUP_PORTS];
    logic [LOOKUP_PORTS-1:0]       res_valid_q, res_hit_q, res_v_q, res_dirty_q;
    logic [LOOKUP_PORTS-1:0]       res_hit_d, res_v_d, res_dirty_d;
    logic [IDX_W*LOOKUP_PORTS-1:0] res_index_q, res_index_d;
    logic [32*LOOKUP_PORTS-1:0]    res_paddr_q, res_paddr_d;
    logic [3*LOOKUP_PORTS-1:0]     res_c_q, res_c_d;
    tlb_entry_t                    sel;
    logic                          odd;

    // Descending scan so the lowest matching index is the last one written.
    always_comb begin
        for (int p = 0; p < int'(LOOKUP_PORTS); p++) begin
            lk_hit[p] = 1'b0;
            lk_idx[p] = '0;
            for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
                if (entry_match(mem_q[i], lk_vaddr[p*32+13 +: 19], asid)) begin
                    lk_hit[p] = 1'b1;
                    lk_idx[p] = IDX_W'(i);
                end
            end
        end
    end

    always_comb begin
        res_hit_d   = '0;
        res_index_d = '0;
        res_paddr_d = '0;
        res_v_d     = '0;
        res_dirty_d = '0;
        res_c_d     = '0;
        sel         = '0;
        odd         = 1'b0;
        for (int p = 0; p < int'(LOOKUP_PORTS); p++) begin
            if (lk_valid[p] && lk_hit[p]) begin
                sel = mem_q[lk_idx[p]];
                odd = lk_vaddr[p*32+12];
                res_hit_d[p]                   = 1'b1;
                res_index_d[p*IDX_W +: IDX_W]  = lk_idx[p];
                res_paddr_d[p*32 +: 32]        = {odd ? sel.pfn1 : sel.pfn0,
                                                  lk_vaddr[p*32 +: 12]};
                res_v_d[p]                     = odd ? sel.v1 : sel.v0;
                res_dirty_d[p]                 = odd ? sel.d1 : sel.d0;
                res_c_d[p*3 +: 3]              = odd ? sel.c1 : sel.c0;
            end
        end
    end

    // ---------------- probe ----------------
    logic             pr_hit;
    logic [IDX_W-1:0] pr_idx;
    logic [31:0]      probe_index_q, probe_index_d;
    logic             probe_ack_q;
    logic             unused_probe;

    assign unused_probe = ^probe_entry_hi[12:8];

    always_comb begin
        pr_hit = 1'b0;
        pr_idx = '0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (entry_match(mem_q[i], probe_entry_hi[31:13], probe_entry_hi[7:0])) begin
                pr_hit = 1'b1;
                pr_idx = IDX_W'(i);
            end
        end
        probe_index_d = {~pr_hit, {(31 - IDX_W){1'b0}}, pr_idx};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q   <= '0;
            res_hit_q     <= '0;
            res_index_q   <= '0;
            res_paddr_q   <= '0;
            res_v_q       <= '0;
            res_dirty_q   <= '0;
            res_c_q       <= '0;
            probe_ack_q   <= 1'b0;
            probe_index_q <= '0;
        end else begin
            res_valid_q   <= lk_valid;
            res_hit_q     <= res_hit_d;
            res_index_q   <= res_index_d;
            res_paddr_q   <= res_paddr_d;
            res_v_q       <= res_v_d;
            res_dirty_q   <= res_dirty_d;
            res_c_q       <= res_c_d;
            probe_ack_q   <= probe_req;
            if (probe_req) begin
                probe_index_q <= probe_index_d;
            end
        end
    end

    assign res_valid   = res_valid_q;
    assign res_hit     = res_hit_q;
    assign res_index   = res_index_q;
    assign res_paddr   = res_paddr_q;
    assign res_v       = res_v_q;
    assign res_d       = res_dirty_q;
    assign res_c       = res_c_q;
    assign probe_ack   = probe_ack_q;
    assign probe_index = probe_index_q;

    // ---------------- Random counter ----------------
    always_comb begin
        if (wired_we || (wired >= LastIdx) || (random_q <= wired)) begin
            random_d = LastIdx;
        end else begin
            random_d = random_q - IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            random_q <= LastIdx;
        end else begin
            random_q <= random_d;
        end
    end

    assign random = random_q;

    // ---------------- invalidate FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (inv_req) state_d = StWalk;
            StWalk:  if (ptr_q == LastIdx) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        inv_busy = 1'b0;
        inv_done = 1'b0;
        walk_en  = 1'b0;
        unique case (state_q)
            StWalk: begin
                inv_busy = 1'b1;
                walk_en  = 1'b1;
            end
            StDone: begin
                inv_busy = 1'b1;
                inv_done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            mode_q     <= 1'b0;
            inv_asid_q <= '0;
        end else if (state_q == StIdle && inv_req) begin
            ptr_q      <= '0;
            mode_q     <= inv_mode;
            inv_asid_q <= inv_asid;
        end else if (walk_en) begin
            ptr_q <= ptr_q + IDX_W'(1);
        end
    end

    // ---------------- entry array ----------------
    assign wr_idx     = wr_random ? random_q : wr_index;
    assign walk_entry = mem_q[ptr_q];
    assign walk_clr   = walk_en &&
                        (!mode_q || (!walk_entry.g && walk_entry.asid == inv_asid_q));

    // A software write to the walker's current slot wins over the invalidate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                if (wr_en && wr_idx == IDX_W'(i)) begin
                    mem_q[i] <= tlb_entry_t'(wr_data);
                end else if (walk_clr && ptr_q == IDX_W'(i)) begin
                    mem_q[i].v0 <= 1'b0;
                    mem_q[i].v1 <= 1'b0;
                end
            end
        end
    end

    assign rd_data = (wr_en && wr_idx == rd_index) ? wr_data : mem_q[rd_index];

endmodule

// File: tb/tb_tlb_mp.sv
// Self-checking bench for tlb_mp: directed scenarios plus randomized lookups and probes
// compared against an array-based reference model.
module tb_tlb_mp;
    localparam int ENTRIES = 32;
    localparam int P       = 2;
    localparam int IDX_W   = 5;
    localparam int EW      = 78;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        asid;
    logic [P-1:0]      lk_valid;
    logic [32*P-1:0]   lk_vaddr;
    logic [P-1:0]      res_valid, res_hit, res_v, res_d;
    logic [IDX_W*P-1:0] res_index;
    logic [32*P-1:0]   res_paddr;
    logic [3*P-1:0]    res_c;
    logic              probe_req;
    logic [31:0]       probe_entry_hi;
    logic              probe_ack;
    logic [31:0]       probe_index;
    logic [IDX_W-1:0]  rd_index;
    logic [EW-1:0]     rd_data;
    logic              wr_en, wr_random;
    logic [IDX_W-1:0]  wr_index;
    logic [EW-1:0]     wr_data;
    logic [IDX_W-1:0]  wired;
    logic              wired_we;
    logic [IDX_W-1:0]  random;
    logic              inv_req, inv_mode;
    logic [7:0]        inv_asid;
    logic              inv_busy, inv_done;

    int errors = 0;
    int checks = 0;

    logic [EW-1:0] m_mem [ENTRIES];

    tlb_mp #(.ENTRIES(ENTRIES), .LOOKUP_PORTS(P)) dut (
        .clk(clk), .rst_n(rst_n), .asid(asid),
        .lk_valid(lk_valid), .lk_vaddr(lk_vaddr),
        .res_valid(res_valid), .res_hit(res_hit), .res_index(res_index),
        .res_paddr(res_paddr), .res_v(res_v), .res_d(res_d), .res_c(res_c),
        .probe_req(probe_req), .probe_entry_hi(probe_entry_hi),
        .probe_ack(probe_ack), .probe_index(probe_index),
        .rd_index(rd_index), .rd_data(rd_data),
        .wr_en(wr_en), .wr_random(wr_random), .wr_index(wr_index), .wr_data(wr_data),
        .wired(wired), .wired_we(wired_we), .random(random),
        .inv_req(inv_req), .inv_mode(inv_mode), .inv_asid(inv_asid),
        .inv_busy(inv_busy), .inv_done(inv_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [EW-1:0] mk(input logic [18:0] vpn2, input logic [7:0] a,
                                         input logic g, input logic [19:0] p0,
                                         input logic [2:0] c0, input logic d0, input logic v0,
                                         input logic [19:0] p1, input logic [2:0] c1,
                                         input logic d1, input logic v1);
        return {vpn2, a, g, p0, c0, d0, v0, p1, c1, d1, v1};
    endfunction

    function automatic logic [EW-1:0] rand_entry(input logic [18:0] vpn2);
        return mk(vpn2, 8'($urandom_range(1, 3)), $urandom_range(0, 3) == 0,
                  20'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
                  20'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
    endfunction

    // Reference translation: first (lowest) entry satisfying the match rule.
    task automatic m_lookup(input logic [31:0] va, input logic [7:0] a, output logic [42:0] r);
        logic [EW-1:0] e;
        r = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            e = m_mem[i];
            if (e[77:59] == va[31:13] && (e[50] || e[58:51] == a)) begin
                if (va[12]) r = {1'b1, 5'(i), e[24:5], va[11:0], e[0], e[1], e[4:2]};
                else        r = {1'b1, 5'(i), e[49:30], va[11:0], e[25], e[26], e[29:27]};
                break;
            end
        end
    endtask

    task automatic m_invalidate(input logic all, input logic [7:0] a);
        for (int i = 0; i < ENTRIES; i++) begin
            if (all || (!m_mem[i][50] && m_mem[i][58:51] == a)) begin
                m_mem[i][25] = 1'b0;
                m_mem[i][0]  = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({res_valid, res_hit, probe_ack, probe_index, inv_busy, inv_done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b/%b/%b/%h/%b/%b want all zero",
                     res_valid, res_hit, probe_ack, probe_index, inv_busy, inv_done);
        end
        checks++;
        if (random !== 5'd31) begin
            errors++;
            $display("FAIL reset_random: got %0d want 31", random);
        end
        for (int i = 0; i < ENTRIES; i++) begin
            rd_index = 5'(i);
            #1;
            checks++;
            if (rd_data !== '0) begin
                errors++;
                $display("FAIL reset_entry[%0d]: got %h want 0", i, rd_data);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < ENTRIES; i++) m_mem[i] = '0;
    endtask

    task automatic test_translate;
        @(negedge clk);
        wr_en = 1; wr_random = 0; wr_index = 5'd3;
        wr_data = mk(19'h40, 8'h05, 0, 20'h12345, 3'd0, 0, 1, 20'h54321, 3'd0, 1, 1);
        m_mem[3] = wr_data;
        @(negedge clk);
        wr_en = 0; asid = 8'h05; lk_valid = 2'b11;
        lk_vaddr = {32'h00081DEF, 32'h00080ABC};
        @(negedge clk);
        lk_valid = 0;
        checks++;
        if (res_valid !== 2'b11 || res_hit !== 2'b11) begin
            errors++;
            $display("FAIL translate_hit: got valid=%b hit=%b want 11/11", res_valid, res_hit);
        end
        checks++;
        if (res_index !== {5'd3, 5'd3}) begin
            errors++;
            $display("FAIL translate_index: got %h want 3/3", res_index);
        end
        checks++;
        if (res_paddr[31:0] !== 32'h12345ABC || res_v[0] !== 1'b1 || res_d[0] !== 1'b0) begin
            errors++;
            $display("FAIL translate_port0: got %h v=%b d=%b want 12345abc v=1 d=0",
                     res_paddr[31:0], res_v[0], res_d[0]);
        end
        checks++;
        if (res_paddr[63:32] !== 32'h54321DEF || res_d[1] !== 1'b1 || res_v[1] !== 1'b1) begin
            errors++;
            $display("FAIL translate_port1: got %h v=%b d=%b want 54321def v=1 d=1",
                     res_paddr[63:32], res_v[1], res_d[1]);
        end
    endtask

    task automatic test_asid_global;
        @(negedge clk);
        asid = 8'h06; lk_valid = 2'b01; lk_vaddr[31:0] = 32'h00080ABC;
        @(negedge clk);
        checks++;
        if (res_valid[0] !== 1'b1 || res_hit[0] !== 1'b0 || res_paddr[31:0] !== '0) begin
            errors++;
            $display("FAIL asid_miss: got hit=%b pa=%h want 0/0", res_hit[0], res_paddr[31:0]);
        end
        // Write g=1 while the lookup is still issued: this cycle must see old contents.
        wr_en = 1; wr_index = 5'd3;
        wr_data = mk(19'h40, 8'h05, 1, 20'h12345, 3'd2, 0, 1, 20'h54321, 3'd0, 1, 1);
        m_mem[3] = wr_data;
        @(negedge clk);
        wr_en = 0;
        checks++;
        if (res_hit[0] !== 1'b0) begin
            errors++;
            $display("FAIL write_same_cycle_old: got hit=%b want 0", res_hit[0]);
        end
        @(negedge clk);
        lk_valid = 0;
        checks++;
        if (res_hit[0] !== 1'b1 || res_paddr[31:0] !== 32'h12345ABC || res_c[2:0] !== 3'd2) begin
            errors++;
            $display("FAIL global_hit: got hit=%b pa=%h c=%0d want 1/12345abc/2",
                     res_hit[0], res_paddr[31:0], res_c[2:0]);
        end
    endtask

    task automatic test_probe_bypass;
        logic [EW-1:0] nd;
        @(negedge clk);
        probe_req = 1; probe_entry_hi = 32'h00080005;
        @(negedge clk);
        probe_entry_hi = 32'h00090005;
        checks++;
        if (probe_ack !== 1'b1 || probe_index !== 32'h00000003) begin
            errors++;
            $display("FAIL probe_hit: got ack=%b idx=%h want 1/00000003", probe_ack, probe_index);
        end
        @(negedge clk);
        probe_req = 0;
        checks++;
        if (probe_ack !== 1'b1 || probe_index !== 32'h80000000) begin
            errors++;
            $display("FAIL probe_miss: got ack=%b idx=%h want 1/80000000", probe_ack, probe_index);
        end
        @(negedge clk);
        checks++;
        if (probe_ack !== 1'b0) begin
            errors++;
            $display("FAIL probe_ack_drop: got %b want 0", probe_ack);
        end
        nd = mk(19'h40, 8'h05, 1, 20'hABCDE, 3'd5, 1, 1, 20'h13579, 3'd6, 0, 1);
        wr_en = 1; wr_random = 0; wr_index = 5'd3; wr_data = nd; rd_index = 5'd3;
        #1;
        checks++;
        if (rd_data !== nd) begin
            errors++;
            $display("FAIL read_bypass: got %h want %h", rd_data, nd);
        end
        rd_index = 5'd4;
        #1;
        checks++;
        if (rd_data !== m_mem[4]) begin
            errors++;
            $display("FAIL read_no_bypass: got %h want %h", rd_data, m_mem[4]);
        end
        m_mem[3] = nd;
        @(negedge clk);
        wr_en = 0; rd_index = 5'd3;
        #1;
        checks++;
        if (rd_data !== nd) begin
            errors++;
            $display("FAIL read_stored: got %h want %h", rd_data, nd);
        end
    endtask

    task automatic test_random;
        logic [4:0] e;
        logic [4:0] w_idx [2];
        int k = 0;
        @(negedge clk);
        wired = 5'd4; wired_we = 1;
        @(negedge clk);
        wired_we = 0;
        for (int n = 0; n < 60; n++) begin
            wr_en = 0; wr_random = 0;
            e = 5'(31 - (n % 28));
            checks++;
            if (random !== e) begin
                errors++;
                $display("FAIL random_seq[%0d]: got %0d want %0d", n, random, e);
            end
            if (n == 35 || n == 50) begin
                wr_en = 1; wr_random = 1; wr_index = 5'd0;
                wr_data = rand_entry(19'h100 + 19'($urandom_range(0, 7)));
                rd_index = e;
                #1;
                checks++;
                if (rd_data !== wr_data) begin
                    errors++;
                    $display("FAIL random_write_bypass[%0d]: got %h want %h", e, rd_data, wr_data);
                end
                m_mem[e] = wr_data;
                w_idx[k] = e;
                k++;
            end
            @(negedge clk);
        end
        wr_en = 0; wr_random = 0;
        checks++;
        if (random !== 5'd27) begin
            errors++;
            $display("FAIL random_pre_we: got %0d want 27", random);
        end
        wired_we = 1;
        @(negedge clk);
        wired_we = 0;
        checks++;
        if (random !== 5'd31) begin
            errors++;
            $display("FAIL random_wired_we: got %0d want 31", random);
        end
        @(negedge clk);
        checks++;
        if (random !== 5'd30) begin
            errors++;
            $display("FAIL random_after_we: got %0d want 30", random);
        end
        wired = 5'd31;
        @(negedge clk);
        for (int n = 0; n < 5; n++) begin
            checks++;
            if (random !== 5'd31) begin
                errors++;
                $display("FAIL random_hold[%0d]: got %0d want 31", n, random);
            end
            @(negedge clk);
        end
        wired = 5'd0;
        for (int j = 0; j < 2; j++) begin
            rd_index = w_idx[j];
            #1;
            checks++;
            if (rd_data !== m_mem[w_idx[j]]) begin
                errors++;
                $display("FAIL random_write_land[%0d]: got %h want %h",
                         w_idx[j], rd_data, m_mem[w_idx[j]]);
            end
        end
    endtask

    task automatic test_lookup_random;
        logic [42:0] e_res [P];
        logic [42:0] got;
        logic [P-1:0] e_valid;
        logic e_pack;
        logic [31:0] e_pidx;
        logic [42:0] pr;
        logic [31:0] va;
        logic [18:0] vpn;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            wr_en = 1; wr_random = 0; wr_index = 5'($urandom_range(0, 31));
            wr_data = rand_entry(19'h100 + 19'($urandom_range(0, 7)));
            m_mem[wr_index] = wr_data;
        end
        @(negedge clk);
        wr_en = 0;
        for (int k = 0; k <= 300; k++) begin
            if (k > 0) begin
                for (int p = 0; p < P; p++) begin
                    checks++;
                    got = {res_hit[p], res_index[p*5 +: 5], res_paddr[p*32 +: 32],
                           res_v[p], res_d[p], res_c[p*3 +: 3]};
                    if (res_valid[p] !== e_valid[p]) begin
                        errors++;
                        $display("FAIL rand_valid[%0d] p%0d: got %b want %b",
                                 k, p, res_valid[p], e_valid[p]);
                    end else if (e_valid[p] && got !== e_res[p]) begin
                        errors++;
                        $display("FAIL rand_lookup[%0d] p%0d: got %h want %h",
                                 k, p, got, e_res[p]);
                    end
                end
                checks++;
                if (probe_ack !== e_pack || (e_pack && probe_index !== e_pidx)) begin
                    errors++;
                    $display("FAIL rand_probe[%0d]: got %b/%h want %b/%h",
                             k, probe_ack, probe_index, e_pack, e_pidx);
                end
            end
            if (k == 300) break;
            asid = 8'($urandom_range(1, 3));
            for (int p = 0; p < P; p++) begin
                vpn = ($urandom_range(0, 7) == 0) ? 19'($urandom)
                                                  : 19'h100 + 19'($urandom_range(0, 7));
                va = {vpn, 13'($urandom)};
                lk_valid[p] = ($urandom_range(0, 3) != 0);
                lk_vaddr[p*32 +: 32] = va;
                e_valid[p] = lk_valid[p];
                m_lookup(va, asid, e_res[p]);
            end
            probe_req = ($urandom_range(0, 1) == 1);
            vpn = 19'h100 + 19'($urandom_range(0, 8));
            probe_entry_hi = {vpn, 5'b0, 8'($urandom_range(1, 3))};
            m_lookup({vpn, 13'b0}, probe_entry_hi[7:0], pr);
            e_pack = probe_req;
            if (probe_req) e_pidx = {~pr[42], 26'b0, pr[41:37]};
            wr_en = ($urandom_range(0, 4) == 0);
            if (wr_en) begin
                wr_index = 5'($urandom_range(0, 31));
                wr_data = rand_entry(19'h100 + 19'($urandom_range(0, 7)));
                m_mem[wr_index] = wr_data;
            end
            @(negedge clk);
        end
        lk_valid = 0; probe_req = 0; wr_en = 0;
    endtask

    task automatic test_inv_asid;
        @(negedge clk);
        wr_en = 1; wr_random = 0;
        wr_index = 5'd1; wr_data = mk(19'h200, 8'h05, 0, 20'h1, 3'd1, 1, 1, 20'h2, 3'd1, 1, 1);
        m_mem[1] = wr_data;
        @(negedge clk);
        wr_index = 5'd2; wr_data = mk(19'h201, 8'h05, 1, 20'h3, 3'd1, 1, 1, 20'h4, 3'd1, 1, 1);
        m_mem[2] = wr_data;
        @(negedge clk);
        wr_index = 5'd9; wr_data = mk(19'h202, 8'h07, 0, 20'h5, 3'd1, 1, 1, 20'h6, 3'd1, 1, 1);
        m_mem[9] = wr_data;
        @(negedge clk);
        wr_en = 0;
        inv_req = 1; inv_mode = 1; inv_asid = 8'h05;
        m_invalidate(1'b0, 8'h05);
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            inv_req = (j == 5);
            inv_mode = (j == 5) ? 1'b0 : 1'b1;
            checks++;
            if ({inv_busy, inv_done} !== {(j <= 33), (j == 33)}) begin
                errors++;
                $display("FAIL inv_timing[%0d]: got busy=%b done=%b want %b/%b",
                         j, inv_busy, inv_done, j <= 33, j == 33);
            end
        end
        inv_req = 0;
        for (int i = 0; i < ENTRIES; i++) begin
            rd_index = 5'(i);
            #1;
            checks++;
            if (rd_data !== m_mem[i]) begin
                errors++;
                $display("FAIL inv_asid_entry[%0d]: got %h want %h", i, rd_data, m_mem[i]);
            end
        end
    endtask

    task automatic test_collision_reset;
        logic [EW-1:0] d7;
        d7 = mk(19'h300, 8'h01, 0, 20'h77, 3'd3, 1, 1, 20'h78, 3'd3, 0, 1);
        @(negedge clk);
        inv_req = 1; inv_mode = 0;
        m_invalidate(1'b1, 8'h00);
        m_mem[7] = d7;
        for (int j = 1; j <= 34; j++) begin
            @(negedge clk);
            inv_req = 0;
            wr_en = (j == 8); wr_random = 0; wr_index = 5'd7; wr_data = d7;
            if (j == 33) begin
                checks++;
                if (inv_done !== 1'b1) begin
                    errors++;
                    $display("FAIL collision_done: got %b want 1", inv_done);
                end
            end
        end
        wr_en = 0;
        for (int i = 0; i < ENTRIES; i++) begin
            rd_index = 5'(i);
            #1;
            checks++;
            if (rd_data !== m_mem[i]) begin
                errors++;
                $display("FAIL collision_entry[%0d]: got %h want %h", i, rd_data, m_mem[i]);
            end
        end
        @(negedge clk);
        inv_req = 1; inv_mode = 0;
        @(negedge clk);
        inv_req = 0;
        repeat (9) @(negedge clk);
        #2 rst_n = 0;
        #1;
        checks++;
        if ({inv_busy, inv_done, res_valid, random} !== {1'b0, 1'b0, 2'b00, 5'd31}) begin
            errors++;
            $display("FAIL reset_mid_walk: got busy=%b done=%b valid=%b random=%0d want 0/0/00/31",
                     inv_busy, inv_done, res_valid, random);
        end
        repeat (2) @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < ENTRIES; i++) m_mem[i] = '0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            checks++;
            if (inv_done !== 1'b0 || inv_busy !== 1'b0) begin
                errors++;
                $display("FAIL no_done_after_reset[%0d]: got busy=%b done=%b want 0/0",
                         j, inv_busy, inv_done);
            end
        end
        rd_index = 5'd7;
        #1;
        checks++;
        if (rd_data !== m_mem[7]) begin
            errors++;
            $display("FAIL reset_clears_entry: got %h want %h", rd_data, m_mem[7]);
        end
    endtask

    initial begin
        rst_n = 0; asid = 0; lk_valid = 0; lk_vaddr = 0;
        probe_req = 0; probe_entry_hi = 0; rd_index = 0;
        wr_en = 0; wr_random = 0; wr_index = 0; wr_data = 0;
        wired = 0; wired_we = 0; inv_req = 0; inv_mode = 0; inv_asid = 0;
        test_reset();
        test_translate();
        test_asid_global();
        test_probe_bypass();
        test_random();
        test_lookup_random();
        test_inv_asid();
        test_collision_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
